// File: rtl/alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_pkg : shared ALU command codes, execute FSM states, address width. rev 1.0
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int REG_AW = 4;

  typedef enum logic [3:0] {
    CMD_ADD = 4'd0,  CMD_SUB = 4'd1,  CMD_AND = 4'd2,  CMD_OR  = 4'd3,
    CMD_XOR = 4'd4,  CMD_NOR = 4'd5,  CMD_NOT = 4'd6,  CMD_SLL = 4'd7,
    CMD_SRL = 4'd8,  CMD_SRA = 4'd9,  CMD_INC = 4'd10, CMD_DEC = 4'd11,
    CMD_SLT = 4'd12, CMD_SGT = 4'd13, CMD_LUI = 4'd14, CMD_HAM = 4'd15
  } alu_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } exec_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_exec_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_exec_seq_if : instruction valid/ready handshake into the execute stage. rev 1.0
// ---------------------------------------------------------------------------
interface alu_exec_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_cmd;
  logic [3:0]  in_rs;
  logic [3:0]  in_rt;
  logic [3:0]  in_rd;
  logic        in_imm_en;
  logic [15:0] in_imm;

  modport master (
    output in_valid, in_cmd, in_rs, in_rt, in_rd, in_imm_en, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_cmd, in_rs, in_rt, in_rd, in_imm_en, in_imm,
    output in_ready
  );
endinterface
`default_nettype wire

// File: rtl/exec_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// exec_regfile : NREG x N bank, 2 read + 1 debug read, 1 sync write, R0 = 0. rev 1.0
// ---------------------------------------------------------------------------
module exec_regfile
  import alu_pkg::*;
#(
  parameter int N    = 32,
  parameter int NREG = 16
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic [REG_AW-1:0] ra_addr,
  output logic      [N-1:0]      ra_data,
  input  wire logic [REG_AW-1:0] rb_addr,
  output logic      [N-1:0]      rb_data,
  input  wire logic [REG_AW-1:0] dbg_addr,
  output logic      [N-1:0]      dbg_data,
  input  wire logic              we,
  input  wire logic [REG_AW-1:0] waddr,
  input  wire logic [N-1:0]      wdata
);

  logic [N-1:0] regs_q [NREG];
  logic [N-1:0] regs_d [NREG];

  function automatic logic [N-1:0] rd_port(input logic [REG_AW-1:0] a);
    return (int'(a) < NREG) ? regs_q[a] : '0;
  endfunction

  assign ra_data  = rd_port(ra_addr);
  assign rb_data  = rd_port(rb_addr);
  assign dbg_data = rd_port(dbg_addr);

  // Entry 0 is forced to zero every cycle, so writes to it simply vanish.
  always_comb begin
    regs_d = regs_q;
    if (we && (int'(waddr) < NREG)) begin
      regs_d[waddr] = wdata;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_exec_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_exec_seq : 4-state execute sequencer feeding an external ALU. rev 1.0
// ---------------------------------------------------------------------------
module alu_exec_seq
  import alu_pkg::*;
#(
  parameter int N    = 32,
  parameter int NREG = 16
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  alu_exec_seq_if.slave          in_if,
  output logic      [N-1:0]      alu_a,
  output logic      [N-1:0]      alu_b,
  output logic      [3:0]        alu_cmd,
  input  wire logic [N-1:0]      alu_z,
  output logic                   wb_valid,
  output logic      [REG_AW-1:0] wb_rd,
  output logic      [N-1:0]      wb_data,
  output logic      [15:0]       retired,
  input  wire logic [REG_AW-1:0] dbg_addr,
  output logic      [N-1:0]      dbg_data
);

  exec_state_e       state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic              imm_en_q, imm_en_d;
  logic [15:0]       imm_q, imm_d;
  logic [N-1:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]        alu_cmd_q, alu_cmd_d;
  logic [N-1:0]      res_q, res_d;
  logic              wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic [15:0]       retired_q, retired_d;
  logic [N-1:0]      ra_data, rb_data;

  exec_regfile #(.N(N), .NREG(NREG)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra_addr  (rs_q),
    .ra_data  (ra_data),
    .rb_addr  (rt_q),
    .rb_data  (rb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (state_q == ST_WB),
    .waddr    (rd_q),
    .wdata    (res_q)
  );

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    imm_en_d   = imm_en_q;
    imm_d      = imm_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_cmd_d  = alu_cmd_q;
    res_d      = res_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    retired_d  = retired_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_if.in_valid && in_ready_q) begin
          cmd_d    = in_if.in_cmd;
          rs_d     = in_if.in_rs;
          rt_d     = in_if.in_rt;
          rd_d     = in_if.in_rd;
          imm_en_d = in_if.in_imm_en;
          imm_d    = in_if.in_imm;
          state_d  = ST_READ;
        end
      end
      ST_READ: begin
        alu_a_d   = ra_data;
        alu_b_d   = imm_en_q ? {{(N-16){imm_q[15]}}, imm_q} : rb_data;
        alu_cmd_d = cmd_q;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        res_d      = alu_z;
        wb_rd_d    = rd_q;
        wb_valid_d = 1'b1;
        state_d    = ST_WB;
      end
      ST_WB: begin
        retired_d = retired_q + 16'd1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered ready: low through reset, high from the first cycle after release.
    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      cmd_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      imm_en_q   <= 1'b0;
      imm_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_cmd_q  <= '0;
      res_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      cmd_q      <= cmd_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      imm_en_q   <= imm_en_d;
      imm_q      <= imm_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_cmd_q  <= alu_cmd_d;
      res_q      <= res_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      retired_q  <= retired_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign alu_cmd        = alu_cmd_q;
  assign wb_valid       = wb_valid_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = res_q;
  assign retired        = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_exec_seq : directed + random bench with its own ALU and register model. rev 1.0
// ---------------------------------------------------------------------------
module tb_alu_exec_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_a, alu_b, alu_z, wb_data, dbg_data;
  logic [3:0]  alu_cmd, wb_rd;
  logic        wb_valid;
  logic [15:0] retired;
  logic [3:0]  dbg_addr = 4'd0;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_regs [16];
  logic [15:0] m_retired;

  alu_exec_seq_if bus ();

  alu_exec_seq #(.N(32), .NREG(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_if    (bus.slave),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_cmd  (alu_cmd),
    .alu_z    (alu_z),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .retired  (retired),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] c);
    case (c)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return ~a;
      4'd7:  return a << b[4:0];
      4'd8:  return a >> b[4:0];
      4'd9:  return $signed(a) >>> b[4:0];
      4'd10: return a + 32'd1;
      4'd11: return a - 32'd1;
      4'd12: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd13: return ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
      4'd14: return a << 16;
      default: return 32'($countones(a));
    endcase
  endfunction

  assign alu_z = alu_fn(alu_a, alu_b, alu_cmd);

  function automatic logic [31:0] sext(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
    m_retired = 16'd0;
  endtask

  task automatic check_dbg(input logic [3:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    check("dbg_read", dbg_data, exp);
  endtask

  // Presents one instruction, waits for acceptance, and checks every cycle to retirement.
  task automatic issue(input logic [3:0] cmd, input logic [3:0] rs, input logic [3:0] rt,
                       input logic [3:0] rd, input logic imm_en, input logic [15:0] imm);
    logic [31:0] ea, eb, ez;
    int guard;
    bus.in_valid  = 1'b1;
    bus.in_cmd    = cmd;
    bus.in_rs     = rs;
    bus.in_rt     = rt;
    bus.in_rd     = rd;
    bus.in_imm_en = imm_en;
    bus.in_imm    = imm;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 16) begin
      tick();
      guard++;
    end
    check("accept_wait", 32'(bus.in_ready), 32'd1);
    ea = m_regs[rs];
    eb = imm_en ? sext(imm) : m_regs[rt];
    ez = alu_fn(ea, eb, cmd);
    tick();
    bus.in_valid = 1'b0;
    check("ready_low_read", 32'(bus.in_ready), 32'd0);
    check("wb_quiet_read", 32'(wb_valid), 32'd0);
    tick();
    check("alu_a", alu_a, ea);
    check("alu_b", alu_b, eb);
    check("alu_cmd", 32'(alu_cmd), 32'(cmd));
    check("wb_quiet_exec", 32'(wb_valid), 32'd0);
    tick();
    check("wb_valid", 32'(wb_valid), 32'd1);
    check("wb_rd", 32'(wb_rd), 32'(rd));
    check("wb_data", wb_data, ez);
    check("alu_a_hold", alu_a, ea);
    tick();
    if (rd != 4'd0) m_regs[rd] = ez;
    m_retired = m_retired + 16'd1;
    check("wb_pulse_end", 32'(wb_valid), 32'd0);
    check("ready_back", 32'(bus.in_ready), 32'd1);
    check("retired", 32'(retired), 32'(m_retired));
    check("wb_data_hold", wb_data, ez);
    check_dbg(rd, m_regs[rd]);
  endtask

  initial begin
    int accepts;
    bus.in_valid  = 1'b0;
    bus.in_cmd    = 4'd0;
    bus.in_rs     = 4'd0;
    bus.in_rt     = 4'd0;
    bus.in_rd     = 4'd0;
    bus.in_imm_en = 1'b0;
    bus.in_imm    = 16'd0;
    model_reset();

    // Reset held for two edges
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_cmd", 32'(alu_cmd), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    rst_n = 1'b1;
    tick();
    check("ready_after_release", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 16; i++) check_dbg(4'(i), 32'd0);

    // Immediate loads
    issue(4'd0, 4'd0, 4'd0, 4'd1, 1'b1, 16'h0005);
    check("imm_r1", wb_data, 32'h0000_0005);
    issue(4'd0, 4'd0, 4'd0, 4'd2, 1'b1, 16'hFFFD);
    check("imm_r2", wb_data, 32'hFFFF_FFFD);
    check("retired_two", 32'(retired), 32'd2);

    // Back-to-back dependent register ops
    issue(4'd1, 4'd1, 4'd2, 4'd3, 1'b0, 16'h0000);
    issue(4'd12, 4'd2, 4'd1, 4'd4, 1'b0, 16'h0000);
    check_dbg(4'd3, 32'h0000_0008);
    check_dbg(4'd4, 32'h0000_0001);

    // R0 stays zero even though the result is reported
    issue(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 16'h0007);
    check("r0_wb_data", wb_data, 32'h0000_0007);
    check_dbg(4'd0, 32'd0);

    // Continuous in_valid: one accept every fourth cycle
    bus.in_valid  = 1'b1;
    bus.in_cmd    = 4'd0;
    bus.in_rs     = 4'd0;
    bus.in_rd     = 4'd0;
    bus.in_imm_en = 1'b1;
    bus.in_imm    = 16'h0009;
    accepts = 0;
    for (int c = 0; c < 16; c++) begin
      check("ready_pattern", 32'(bus.in_ready), ((c % 4) == 0) ? 32'd1 : 32'd0);
      if (bus.in_ready === 1'b1) accepts++;
      tick();
    end
    bus.in_valid = 1'b0;
    check("accept_count", 32'(accepts), 32'd4);
    m_retired = m_retired + 16'd4;
    check("retired_stream", 32'(retired), 32'(m_retired));

    // Reset during EXEC abandons the instruction
    bus.in_valid = 1'b1;
    bus.in_rd    = 4'd6;
    bus.in_imm   = 16'h1234;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("abort_in_exec", 32'(alu_a), 32'd0);
    rst_n = 1'b0;
    tick();
    model_reset();
    check("abort_ready_low", 32'(bus.in_ready), 32'd0);
    check("abort_no_wb", 32'(wb_valid), 32'd0);
    check("abort_retired", 32'(retired), 32'd0);
    rst_n = 1'b1;
    tick();
    check("abort_no_wb_late", 32'(wb_valid), 32'd0);
    check("abort_ready_back", 32'(bus.in_ready), 32'd1);
    tick();
    check("abort_no_wb_late2", 32'(wb_valid), 32'd0);
    check_dbg(4'd6, 32'd0);

    // Random instructions against the model
    for (int n = 0; n < 40; n++) begin
      issue(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
            1'($urandom), 16'($urandom));
    end

    // Retired counter wraps at 16 bits
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    #1;
    m_retired = 16'hFFFF;
    check("retired_preload", 32'(retired), 32'h0000_FFFF);
    issue(4'd10, 4'd3, 4'd0, 4'd7, 1'b0, 16'h0000);
    check("retired_wrap", 32'(retired), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
